// File: rtl/cmp_issue_queue_if.sv
// cmp_issue_queue_if: decode-side enqueue port, result broadcast buses,
// station free flags and the dispatch port of the compare issue queue.
// master = producer/consumer side (decode, RS, broadcasters); slave = queue.
interface cmp_issue_queue_if #(
  parameter int NUM_RS = 2
);

  typedef struct packed {
    logic [4:0]  reg_id;   // 0 = bus idle
    logic [31:0] data;
  } command_buffer;

  // enqueue
  logic              enq_valid;
  logic              enq_ready;
  logic [4:0]        enq_dest;
  logic [4:0]        enq_r1;
  logic [4:0]        enq_r2;
  logic [31:0]       enq_src1;
  logic [31:0]       enq_src2;
  logic [2:0]        enq_funct3;

  // result broadcasts
  command_buffer     cmd_buf_alu;
  command_buffer     cmd_buf_ld_str;
  command_buffer     cmd_buf_mul;
  command_buffer     cmd_buf_div;

  // dispatch
  logic [NUM_RS-1:0] rs_free;
  logic [NUM_RS-1:0] iq_assert;
  logic [4:0]        destination;
  logic [4:0]        r1_o;
  logic [4:0]        r2_o;
  logic [31:0]       src1_o;
  logic [31:0]       src2_o;
  logic [2:0]        funct3_o;

  modport master (
    output enq_valid, enq_dest, enq_r1, enq_r2, enq_src1, enq_src2, enq_funct3,
    output cmd_buf_alu, cmd_buf_ld_str, cmd_buf_mul, cmd_buf_div,
    output rs_free,
    input  enq_ready, iq_assert, destination, r1_o, r2_o, src1_o, src2_o, funct3_o
  );

  modport slave (
    input  enq_valid, enq_dest, enq_r1, enq_r2, enq_src1, enq_src2, enq_funct3,
    input  cmd_buf_alu, cmd_buf_ld_str, cmd_buf_mul, cmd_buf_div,
    input  rs_free,
    output enq_ready, iq_assert, destination, r1_o, r2_o, src1_o, src2_o, funct3_o
  );

endinterface

// File: rtl/cmp_issue_queue.sv
// cmp_issue_queue: circular issue queue feeding NUM_RS branch-compare
// reservation stations. Waiting source tags snoop four result broadcast
// buses (priority div > mul > ld_str > alu), both in storage, at enqueue and
// combinationally on the dispatch outputs.
// Optional feature: define CMP_ISSUE_QUEUE_BYPASS_EN to dispatch an enqueue
// straight through in the same cycle when the queue is empty.
module cmp_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int NUM_RS = 2
) (
  input  logic                   clk,
  input  logic                   reset,   // async, active-low
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  cmp_issue_queue_if.slave       bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Bit-packed {tag, value}: returns the value with the tag cleared when a
  // nonzero tag matches a broadcast; later (higher) index wins, index 3 = div.
  function automatic logic [36:0] wake(input logic [36:0] cur,
                                       input logic [3:0][36:0] bcs);
    logic [36:0] res;
    res = cur;
    for (int k = 0; k < 4; k++) begin
      if (cur[36:32] != 5'd0 && bcs[k][36:32] == cur[36:32])
        res = {5'd0, bcs[k][31:0]};
    end
    return res;
  endfunction

  logic [3:0][36:0]  bcs;
  logic [NUM_RS-1:0] rs_free;
  logic [NUM_RS-1:0] rs_sel;

  logic [AW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;

  logic [4:0]  dest_arr   [DEPTH];
  logic [4:0]  r1_arr     [DEPTH];
  logic [4:0]  r2_arr     [DEPTH];
  logic [31:0] src1_arr   [DEPTH];
  logic [31:0] src2_arr   [DEPTH];
  logic [2:0]  funct3_arr [DEPTH];

  logic [36:0] enq_w1, enq_w2, head_w1, head_w2;
  logic        enq_ready;
  logic        q_take, byp_take, do_enq;

  assign bcs     = {bus.cmd_buf_div, bus.cmd_buf_mul, bus.cmd_buf_ld_str, bus.cmd_buf_alu};
  assign rs_free = bus.rs_free;
  assign rs_sel  = rs_free & (~rs_free + 1'b1);   // lowest free station

  assign enq_w1  = wake({bus.enq_r1, bus.enq_src1}, bcs);
  assign enq_w2  = wake({bus.enq_r2, bus.enq_src2}, bcs);
  assign head_w1 = wake({r1_arr[head_reg], src1_arr[head_reg]}, bcs);
  assign head_w2 = wake({r2_arr[head_reg], src2_arr[head_reg]}, bcs);

  // Full queue refuses enqueue even if the head leaves this cycle.
  assign enq_ready     = reset && (count_reg < DEPTH_C);
  assign bus.enq_ready = enq_ready;
  assign count         = count_reg;

  assign q_take = reset && !flush && (count_reg != '0) && (rs_free != '0);
`ifdef CMP_ISSUE_QUEUE_BYPASS_EN
  assign byp_take = reset && !flush && (count_reg == '0) && bus.enq_valid && (rs_free != '0);
`else
  assign byp_take = 1'b0;
`endif
  assign do_enq = bus.enq_valid && enq_ready && !flush && !byp_take;

  // Dispatch port: head entry (or bypassed enqueue) with same-cycle wakeup.
  always_comb begin
    bus.iq_assert   = '0;
    bus.destination = '0;
    bus.r1_o        = '0;
    bus.r2_o        = '0;
    bus.src1_o      = '0;
    bus.src2_o      = '0;
    bus.funct3_o    = '0;
    if (q_take) begin
      bus.iq_assert   = rs_sel;
      bus.destination = dest_arr[head_reg];
      {bus.r1_o, bus.src1_o} = head_w1;
      {bus.r2_o, bus.src2_o} = head_w2;
      bus.funct3_o    = funct3_arr[head_reg];
    end else if (byp_take) begin
      bus.iq_assert   = rs_sel;
      bus.destination = bus.enq_dest;
      {bus.r1_o, bus.src1_o} = enq_w1;
      {bus.r2_o, bus.src2_o} = enq_w2;
      bus.funct3_o    = bus.enq_funct3;
    end
  end

  // Pointer and occupancy bookkeeping; flush and reset empty the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_enq) tail_reg <= tail_reg + 1'b1;
      if (q_take) head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + {{(CW-1){1'b0}}, do_enq} - {{(CW-1){1'b0}}, q_take};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [4:0]  r1_reg, r2_reg, dest_reg;
      logic [31:0] src1_reg, src2_reg;
      logic [2:0]  funct3_reg;
      logic [36:0] w1, w2;
      logic        wr;

      assign wr = do_enq && (tail_reg == AW'(gi));
      assign w1 = wake({r1_reg, src1_reg}, bcs);
      assign w2 = wake({r2_reg, src2_reg}, bcs);

      // Tags: load on enqueue, otherwise clear when a broadcast matches.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r1_reg <= '0;
          r2_reg <= '0;
        end else if (wr) begin
          r1_reg <= enq_w1[36:32];
          r2_reg <= enq_w2[36:32];
        end else begin
          r1_reg <= w1[36:32];
          r2_reg <= w2[36:32];
        end
      end

      // Payload: load on enqueue, otherwise capture broadcast data.
      always_ff @(posedge clk) begin
        if (wr) begin
          dest_reg   <= bus.enq_dest;
          funct3_reg <= bus.enq_funct3;
          src1_reg   <= enq_w1[31:0];
          src2_reg   <= enq_w2[31:0];
        end else begin
          src1_reg   <= w1[31:0];
          src2_reg   <= w2[31:0];
        end
      end

      assign dest_arr[gi]   = dest_reg;
      assign r1_arr[gi]     = r1_reg;
      assign r2_arr[gi]     = r2_reg;
      assign src1_arr[gi]   = src1_reg;
      assign src2_arr[gi]   = src2_reg;
      assign funct3_arr[gi] = funct3_reg;
    end
  endgenerate

endmodule

// File: tb/tb_cmp_issue_queue.sv
// tb_cmp_issue_queue: directed vectors for cmp_issue_queue (DEPTH=4, NUM_RS=2).
// Same-cycle bypass checks follow CMP_ISSUE_QUEUE_BYPASS_EN.
module tb_cmp_issue_queue;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  int         n_vec;
  int         n_bad;

  cmp_issue_queue_if #(.NUM_RS(2)) bus ();

  cmp_issue_queue #(.DEPTH(4), .NUM_RS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .count (count),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.enq_valid      = 1'b0;
    bus.enq_dest       = '0;
    bus.enq_r1         = '0;
    bus.enq_r2         = '0;
    bus.enq_src1       = '0;
    bus.enq_src2       = '0;
    bus.enq_funct3     = '0;
    bus.cmd_buf_alu    = '0;
    bus.cmd_buf_ld_str = '0;
    bus.cmd_buf_mul    = '0;
    bus.cmd_buf_div    = '0;
    bus.rs_free        = '0;
    flush              = 1'b0;
  endtask

  task automatic enq(input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] s1, input logic [31:0] s2, input logic [2:0] f3);
    bus.enq_valid  = 1'b1;
    bus.enq_dest   = d;
    bus.enq_r1     = r1;
    bus.enq_r2     = r2;
    bus.enq_src1   = s1;
    bus.enq_src2   = s2;
    bus.enq_funct3 = f3;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    clr();
    #2;
    chk("rst_iq_assert", bus.iq_assert, 2'b00);
    chk("rst_enq_ready", bus.enq_ready, 1'b0);
    chk("rst_count", count, 3'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("post_rst_enq_ready", bus.enq_ready, 1'b1);

    // basic enqueue then dispatch next cycle
    enq(5'd5, 5'd0, 5'd0, 32'd3, 32'd3, 3'b000);
    #1 chk("t1_empty_iq", bus.iq_assert, 2'b00);
    tick();
    clr();
    bus.rs_free = 2'b01;
    #1;
    chk("t1_iq_assert", bus.iq_assert, 2'b01);
    chk("t1_dest", bus.destination, 5'd5);
    chk("t1_src1", bus.src1_o, 32'd3);
    chk("t1_src2", bus.src2_o, 32'd3);
    chk("t1_count_before", count, 3'd1);
    tick();
    bus.rs_free = 2'b00;
    #1 chk("t1_count_after", count, 3'd0);

    // fill to full, refuse extra enqueue, drain in FIFO order
    for (int k = 0; k < 4; k++) begin
      enq(5'(10 + k), 5'd0, 5'd0, 32'(100 + k), 32'd0, 3'(k));
      tick();
    end
    clr();
    #1;
    chk("t2_count_full", count, 3'd4);
    chk("t2_enq_ready_full", bus.enq_ready, 1'b0);
    enq(5'd31, 5'd0, 5'd0, 32'd999, 32'd0, 3'd7);
    tick();
    clr();
    #1 chk("t2_count_still_full", count, 3'd4);
    bus.rs_free = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_iq_assert", bus.iq_assert, 2'b10);
      chk("t2_dest_order", bus.destination, 5'(10 + k));
      chk("t2_src1_order", bus.src1_o, 32'(100 + k));
      tick();
    end
    #1;
    chk("t2_count_drained", count, 3'd0);
    chk("t2_iq_empty", bus.iq_assert, 2'b00);
    chk("t2_dest_empty", bus.destination, 5'd0);
    clr();

    // wakeup of a stored tag, then dispatch
    enq(5'd1, 5'd7, 5'd0, 32'd0, 32'd4, 3'b001);
    tick();
    clr();
    bus.cmd_buf_mul = {5'd7, 32'h55};
    #1 chk("t3_no_disp", bus.iq_assert, 2'b00);
    tick();
    clr();
    bus.rs_free = 2'b11;
    #1;
    chk("t3_lowest_rs", bus.iq_assert, 2'b01);
    chk("t3_r1_cleared", bus.r1_o, 5'd0);
    chk("t3_src1_captured", bus.src1_o, 32'h55);
    chk("t3_src2_kept", bus.src2_o, 32'd4);
    tick();
    clr();

    // broadcast in the dispatch cycle is forwarded
    enq(5'd2, 5'd7, 5'd0, 32'hdead, 32'd0, 3'b000);
    tick();
    clr();
    bus.rs_free = 2'b01;
    #1 chk("t3b_r1_waiting", bus.r1_o, 5'd7);
    bus.cmd_buf_mul = {5'd7, 32'h55};
    #1;
    chk("t3b_r1_fwd", bus.r1_o, 5'd0);
    chk("t3b_src1_fwd", bus.src1_o, 32'h55);
    tick();
    clr();

    // broadcast in the enqueue cycle is captured
    enq(5'd3, 5'd0, 5'd8, 32'd0, 32'd0, 3'b000);
    bus.cmd_buf_alu = {5'd8, 32'h77};
    tick();
    clr();
    bus.rs_free = 2'b01;
    #1;
    chk("t3c_r2_cleared", bus.r2_o, 5'd0);
    chk("t3c_src2_captured", bus.src2_o, 32'h77);
    tick();
    clr();

    // div beats alu on the same tag
    enq(5'd4, 5'd9, 5'd0, 32'd0, 32'd0, 3'b000);
    tick();
    clr();
    bus.cmd_buf_alu = {5'd9, 32'd1};
    bus.cmd_buf_div = {5'd9, 32'd2};
    tick();
    clr();
    bus.rs_free = 2'b01;
    #1;
    chk("t4_prio_src1", bus.src1_o, 32'd2);
    chk("t4_prio_r1", bus.r1_o, 5'd0);
    tick();
    clr();

    // flush with 3 entries plus a simultaneous enqueue
    for (int k = 0; k < 3; k++) begin
      enq(5'(20 + k), 5'd0, 5'd0, 32'd0, 32'd0, 3'd0);
      tick();
    end
    clr();
    #1 chk("t5_count3", count, 3'd3);
    flush = 1'b1;
    enq(5'd30, 5'd0, 5'd0, 32'd0, 32'd0, 3'd0);
    bus.rs_free = 2'b01;
    #1 chk("t5_flush_iq", bus.iq_assert, 2'b00);
    tick();
    clr();
    bus.rs_free = 2'b01;
    #1;
    chk("t5_count0", count, 3'd0);
    chk("t5_iq_after", bus.iq_assert, 2'b00);
    clr();
    enq(5'd25, 5'd0, 5'd0, 32'd0, 32'd0, 3'd0);
    tick();
    clr();
    bus.rs_free = 2'b01;
    #1 chk("t5_post_flush_dest", bus.destination, 5'd25);
    tick();
    clr();

    // empty-queue enqueue latency
    enq(5'd6, 5'd0, 5'd0, 32'd9, 32'd0, 3'd2);
    bus.rs_free = 2'b01;
    #1;
`ifdef CMP_ISSUE_QUEUE_BYPASS_EN
    chk("t6_bypass_iq", bus.iq_assert, 2'b01);
    chk("t6_bypass_dest", bus.destination, 5'd6);
    tick();
    bus.enq_valid = 1'b0;
    #1;
    chk("t6_bypass_count", count, 3'd0);
    chk("t6_bypass_iq_after", bus.iq_assert, 2'b00);
`else
    chk("t6_lat_iq0", bus.iq_assert, 2'b00);
    tick();
    bus.enq_valid = 1'b0;
    #1;
    chk("t6_lat_iq1", bus.iq_assert, 2'b01);
    chk("t6_lat_dest", bus.destination, 5'd6);
    tick();
    #1 chk("t6_lat_count", count, 3'd0);
`endif
    clr();

    // reset in the middle of a dispatch
    enq(5'd11, 5'd0, 5'd0, 32'd0, 32'd0, 3'd0);
    tick();
    enq(5'd12, 5'd0, 5'd0, 32'd0, 32'd0, 3'd0);
    tick();
    clr();
    bus.rs_free = 2'b01;
    #1;
    chk("t7_disp", bus.iq_assert, 2'b01);
    chk("t7_disp_dest", bus.destination, 5'd11);
    reset = 1'b0;
    #1;
    chk("t7_rst_iq", bus.iq_assert, 2'b00);
    chk("t7_rst_dest", bus.destination, 5'd0);
    chk("t7_rst_count", count, 3'd0);
    chk("t7_rst_enq_ready", bus.enq_ready, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("t7_rel_enq_ready", bus.enq_ready, 1'b1);
    chk("t7_rel_count", count, 3'd0);
    chk("t7_rel_iq", bus.iq_assert, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_issue_queue.md
CMP_ISSUE_QUEUE -- requirements
Module: cmp_issue_queue

Interface
REQ-001 SHALL expose parameter DEPTH, default 4, meaning number of queue entries (power of two, minimum 2).
REQ-002 SHALL expose parameter NUM_RS, default 2, meaning number of compare reservation stations served.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have ports enq_valid input 1 and enq_ready output 1, forming the decode-side enqueue handshake.
REQ-006 SHALL have ports enq_dest, enq_r1, enq_r2  input  5 each  destination tag and source tags (0 = operand ready).
REQ-007 SHALL have ports enq_src1, enq_src2  input  32 each  operand values, valid when the matching tag is 0.
REQ-008 SHALL have port enq_funct3  input  3  branch compare code.
REQ-009 SHALL have ports cmd_buf_alu, cmd_buf_ld_str, cmd_buf_mul, cmd_buf_div  input  command_buffer each  result broadcasts; reg_id 0 means idle.
REQ-010 SHALL have port rs_free  input  NUM_RS  free flag from each station.
REQ-011 SHALL have port iq_assert  output  NUM_RS  one-hot dispatch strobe, one bit per station.
REQ-012 SHALL have ports destination, r1_o, r2_o  output  5 each; src1_o, src2_o  output  32 each; funct3_o  output  3: the dispatched operation fields.
REQ-013 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-014 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL store entries in a circular buffer with head and tail pointers wrapping modulo DEPTH.
REQ-016 SHALL drive enq_ready = (count < DEPTH), with no same-cycle credit for a simultaneous dispatch when full.
REQ-017 SHALL write the entry at tail and advance tail on an edge where enq_valid && enq_ready.
REQ-018 SHALL, when count > 0 and rs_free != 0, raise exactly the iq_assert bit of the lowest-index free station, with the head fields driven on the outputs in the same cycle.
REQ-019 SHALL pop the head on the edge ending a cycle with any iq_assert bit high; dispatch throughput SHALL be 1 per cycle.
REQ-020 SHALL hold iq_assert at 0 and all field outputs at 0 when the queue is empty or rs_free == 0.
REQ-021 SHALL, every cycle, update each stored entry with nonzero r1/r2 matching a nonzero broadcast reg_id: copy the broadcast data into src and clear the tag to 0.
REQ-022 SHALL resolve multiple broadcasts matching one tag with priority div > mul > ld_str > alu.
REQ-023 SHALL apply the same capture to enqueue operands in their enqueue cycle.
REQ-024 SHALL forward same-cycle broadcast matches combinationally onto r1_o/r2_o/src1_o/src2_o during dispatch.
REQ-025 SHALL apply the same-cycle forwarding of REQ-024 so that a dispatched station never misses a broadcast.
REQ-026 SHALL keep count equal to enqueues minus dispatches; simultaneous enqueue and dispatch SHALL leave count unchanged.
REQ-027 SHALL, on flush, zero count and both pointers at the next edge, suppress iq_assert in the flush cycle, and ignore any enqueue in that cycle.

Reset
REQ-028 SHALL, while reset is 0, immediately force count, head and tail to 0, and tag fields of all entries to 0.
REQ-029 SHALL, while reset is 0, force iq_assert to 0, all field outputs to 0, and enq_ready to 0.
REQ-030 SHALL drive enq_ready to 1 in the first cycle after reset deasserts; reset mid-operation SHALL discard all entries.

Configuration
REQ-031 SHALL, with macro CMP_ISSUE_QUEUE_BYPASS_EN defined, dispatch enqueue data directly in the same cycle (zero latency, entry not written) when count == 0, enq_valid == 1, rs_free != 0 and flush == 0.
REQ-032 SHALL, with CMP_ISSUE_QUEUE_BYPASS_EN undefined, have minimum enqueue-to-iq_assert latency of one cycle.

Verification
REQ-033 SHALL verify: enqueue dest=5, r1=r2=0, src1=3, src2=3, funct3=000, rs_free=01 -> next cycle iq_assert=01, destination=5, src1_o=src2_o=3, count returns to 0.
REQ-034 SHALL verify: 4 enqueues with rs_free=00 -> count=4, enq_ready=0; then rs_free=10 -> iq_assert=10 for 4 consecutive cycles, entries in FIFO order.
REQ-035 SHALL verify: queued entry r1=7; cmd_buf_mul.reg_id=7, data=0x55 -> entry r1 becomes 0, src1=0x55; same test with dispatch in the broadcast cycle -> r1_o=0, src1_o=0x55.
REQ-036 SHALL verify: alu and div both broadcast reg_id=9 with data 1 and 2 -> waiting tag 9 captures 2.
REQ-037 SHALL verify: flush with count=3 plus a simultaneous enqueue -> count=0 next cycle, iq_assert=0 in the flush cycle.
REQ-038 SHALL verify: reset asserted mid-dispatch -> iq_assert=0 immediately; with CMP_ISSUE_QUEUE_BYPASS_EN defined, an empty-queue enqueue with rs_free=01 -> iq_assert=01 in the same cycle.
